// File: rtl/fp_mac_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_mac_issuer: in-order tag issue and reorder buffer for a shared FP MAC |
// | Optional same-cycle result bypass: define FP_MAC_ISSUER_BYPASS_EN. Rev 1.0 |
// +--------------------------------------------------------------------------+
module fp_mac_issuer #(
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [FP_WIDTH-1:0]   req_opa_i,
  input  logic [FP_WIDTH-1:0]   req_opb_i,
  input  logic [FP_WIDTH-1:0]   req_opc_i,
  input  logic [1:0]            req_op_i,
  input  logic [RND_WIDTH-1:0]  req_rnd_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [FP_WIDTH-1:0]   rsp_res_o,
  output logic [STAT_WIDTH-1:0] rsp_status_o,
  output logic                  mac_en_o,
  output logic [FP_WIDTH-1:0]   mac_opa_o,
  output logic [FP_WIDTH-1:0]   mac_opb_o,
  output logic [FP_WIDTH-1:0]   mac_opc_o,
  output logic [1:0]            mac_op_o,
  output logic [TAG_WIDTH-1:0]  mac_tag_o,
  output logic [RND_WIDTH-1:0]  mac_rnd_o,
  input  logic                  mac_ready_i,
  input  logic                  mac_valid_i,
  input  logic [TAG_WIDTH-1:0]  mac_tag_i,
  input  logic [FP_WIDTH-1:0]   mac_res_i,
  input  logic [STAT_WIDTH-1:0] mac_status_i,
  output logic                  err_o
);

  localparam int                 DEPTH   = 2 ** TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] DEPTH_C = (TAG_WIDTH + 1)'(DEPTH);

  logic [TAG_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_WIDTH:0]    count_q, count_d;
  logic [DEPTH-1:0]      done_q, done_d;
  logic [FP_WIDTH-1:0]   res_q  [DEPTH];
  logic [STAT_WIDTH-1:0] stat_q [DEPTH];
  logic                  err_q;

  logic                  mac_en_q;
  logic [FP_WIDTH-1:0]   mac_opa_q, mac_opb_q, mac_opc_q;
  logic [1:0]            mac_op_q;
  logic [TAG_WIDTH-1:0]  mac_tag_q;
  logic [RND_WIDTH-1:0]  mac_rnd_q;

  logic                  accept, retire, tag_live, err_hit, bypass, wr_en;
  logic [TAG_WIDTH-1:0]  tag_off;

  // Ready comes from the registered count only, so a same-cycle retire never frees a slot early.
  assign req_ready_o = mac_ready_i & (count_q < DEPTH_C);
  assign accept      = req_valid_i & req_ready_o;

  // A tag is live when its distance from head (mod DEPTH) is below the occupancy.
  assign tag_off  = mac_tag_i - head_q;
  assign tag_live = (count_q != '0) & ({1'b0, tag_off} < count_q);
  assign err_hit  = mac_valid_i & (~tag_live | done_q[mac_tag_i]);

`ifdef FP_MAC_ISSUER_BYPASS_EN
  assign bypass = mac_valid_i & tag_live & (mac_tag_i == head_q) & ~done_q[head_q];
`else
  assign bypass = 1'b0;
`endif

  assign rsp_valid_o  = done_q[head_q] | bypass;
  assign rsp_res_o    = bypass ? mac_res_i    : res_q[head_q];
  assign rsp_status_o = bypass ? mac_status_i : stat_q[head_q];
  assign retire       = rsp_valid_o & rsp_ready_i;
  assign wr_en        = mac_valid_i & ~err_hit & ~(bypass & rsp_ready_i);

  always_comb begin
    done_d  = done_q;
    head_d  = head_q + TAG_WIDTH'(retire);
    tail_d  = tail_q + TAG_WIDTH'(accept);
    count_d = count_q + (TAG_WIDTH + 1)'(accept) - (TAG_WIDTH + 1)'(retire);
    if (retire) done_d[head_q] = 1'b0;
    if (wr_en)  done_d[mac_tag_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      mac_en_q  <= 1'b0;
      mac_opa_q <= '0;
      mac_opb_q <= '0;
      mac_opc_q <= '0;
      mac_op_q  <= '0;
      mac_tag_q <= '0;
      mac_rnd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i]  <= '0;
        stat_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      done_q   <= done_d;
      err_q    <= err_q | err_hit;
      mac_en_q <= accept;
      if (accept) begin
        mac_opa_q <= req_opa_i;
        mac_opb_q <= req_opb_i;
        mac_opc_q <= req_opc_i;
        mac_op_q  <= req_op_i;
        mac_tag_q <= tail_q;
        mac_rnd_q <= req_rnd_i;
      end
      if (wr_en) begin
        res_q[mac_tag_i]  <= mac_res_i;
        stat_q[mac_tag_i] <= mac_status_i;
      end
    end
  end

  assign mac_en_o  = mac_en_q;
  assign mac_opa_o = mac_opa_q;
  assign mac_opb_o = mac_opb_q;
  assign mac_opc_o = mac_opc_q;
  assign mac_op_o  = mac_op_q;
  assign mac_tag_o = mac_tag_q;
  assign mac_rnd_o = mac_rnd_q;
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mac_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_mac_issuer: directed scoreboard bench for fp_mac_issuer. Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_fp_mac_issuer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [31:0] req_opa_i = '0, req_opb_i = '0, req_opc_i = '0;
  logic [1:0]  req_op_i = '0;
  logic [2:0]  req_rnd_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_res_o;
  logic [7:0]  rsp_status_o;
  logic        mac_en_o;
  logic [31:0] mac_opa_o, mac_opb_o, mac_opc_o;
  logic [1:0]  mac_op_o, mac_tag_o;
  logic [2:0]  mac_rnd_o;
  logic        mac_ready_i = 1'b1, mac_valid_i = 1'b0;
  logic [1:0]  mac_tag_i = '0;
  logic [31:0] mac_res_i = '0;
  logic [7:0]  mac_status_i = '0;
  logic        err_o;

  fp_mac_issuer #(.FP_WIDTH(32), .TAG_WIDTH(2), .RND_WIDTH(3), .STAT_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opa_i(req_opa_i), .req_opb_i(req_opb_i), .req_opc_i(req_opc_i),
    .req_op_i(req_op_i), .req_rnd_i(req_rnd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_status_o(rsp_status_o),
    .mac_en_o(mac_en_o), .mac_opa_o(mac_opa_o), .mac_opb_o(mac_opb_o),
    .mac_opc_o(mac_opc_o), .mac_op_o(mac_op_o), .mac_tag_o(mac_tag_o),
    .mac_rnd_o(mac_rnd_o), .mac_ready_i(mac_ready_i), .mac_valid_i(mac_valid_i),
    .mac_tag_i(mac_tag_i), .mac_res_i(mac_res_i), .mac_status_i(mac_status_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [7:0]  st;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_tag  = '0;
  logic [31:0] rv [4] = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};
  logic [7:0]  sv [4] = '{8'h00, 8'h10, 8'h01, 8'h02};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    mac_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    mac_ready_i = 1'b1;
    exp_q.delete();
    exp_tag = '0;
    @(negedge clk);
    chk("rst_mac_en", mac_en_o, 0);
    chk("rst_mac_tag", mac_tag_o, 0);
    chk("rst_mac_opa", mac_opa_o, 0);
    chk("rst_mac_op", mac_op_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [1:0] op, input logic [2:0] rnd,
                       input logic [31:0] r, input logic [7:0] s);
    int w = 0;
    req_opa_i = a; req_opb_i = b; req_opc_i = c; req_op_i = op; req_rnd_i = rnd;
    req_valid_i = 1'b1;
    @(negedge clk);
    while (!req_ready_o && w < 20) begin
      cyc();
      @(negedge clk);
      w++;
    end
    if (!req_ready_o) begin
      chk("issue_timeout", 0, 1);
      req_valid_i = 1'b0;
      return;
    end
    exp_q.push_back({r, s});
    cyc();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("mac_en_pulse", mac_en_o, 1);
    chk("mac_tag", mac_tag_o, exp_tag);
    chk("mac_opa", mac_opa_o, a);
    chk("mac_opb", mac_opb_o, b);
    chk("mac_opc", mac_opc_o, c);
    chk("mac_op", mac_op_o, op);
    chk("mac_rnd", mac_rnd_o, rnd);
    exp_tag++;
    cyc();
  endtask

  task automatic ret(input logic [1:0] tag, input logic [31:0] r, input logic [7:0] s);
    mac_valid_i = 1'b1; mac_tag_i = tag; mac_res_i = r; mac_status_i = s;
    cyc();
    mac_valid_i = 1'b0;
  endtask

  // In-order response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_res", rsp_res_o, e.res);
          chk("rsp_status", rsp_status_o, e.st);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single MAC: 2*3+1 = 7.
    do_reset();
    rsp_ready_i = 1'b1;
    issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00, 3'd0, 32'h40E00000, 8'h00);
    @(negedge clk);
    chk("mac_en_single_cycle", mac_en_o, 0);
    chk("mac_opa_held", mac_opa_o, 32'h40000000);
    cyc();
    mac_valid_i = 1'b1; mac_tag_i = 2'd0; mac_res_i = 32'h40E00000; mac_status_i = 8'h00;
    @(negedge clk);
    chk("no_bypass_t0", rsp_valid_o, 0);
    cyc();
    mac_valid_i = 1'b0;
    @(negedge clk);
    chk("rsp_valid_next", rsp_valid_o, 1);
    cyc();

    // Negated addend: 2*3-1 = 5, next tag.
    issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b01, 3'd1, 32'h40A00000, 8'h01);
    ret(2'd1, 32'h40A00000, 8'h01);
    repeat (2) cyc();

    // Fill, then out-of-order return 2,0,1,3.
    do_reset();
    for (int i = 0; i < 4; i++)
      issue(32'h3F800000 + i, 32'h40000000, 32'h0, 2'b10, 3'(i), rv[i], sv[i]);
    @(negedge clk);
    chk("full_not_ready", req_ready_o, 0);
    cyc();
    mac_valid_i = 1'b1; mac_tag_i = 2'd2; mac_res_i = rv[2]; mac_status_i = sv[2];
    @(negedge clk);
    chk("head_wait_t2", rsp_valid_o, 0);
    cyc();
    mac_tag_i = 2'd0; mac_res_i = rv[0]; mac_status_i = sv[0];
    @(negedge clk);
    chk("head_wait_t0", rsp_valid_o, 0);
    cyc();
    mac_valid_i = 1'b0;
    @(negedge clk);
    chk("head_ready", rsp_valid_o, 1);
    chk("head_res", rsp_res_o, rv[0]);
    chk("still_full", req_ready_o, 0);
    cyc();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("ready_registered", req_ready_o, 0);
    cyc();
    @(negedge clk);
    chk("ready_after_retire", req_ready_o, 1);
    chk("head1_wait", rsp_valid_o, 0);
    cyc();
    ret(2'd1, rv[1], sv[1]);
    ret(2'd3, rv[3], sv[3]);
    repeat (4) cyc();

    // Result for a tag that is not outstanding.
    do_reset();
    rsp_ready_i = 1'b1;
    issue(32'h1, 32'h2, 32'h3, 2'b00, 3'd0, 32'h11111111, 8'h00);
    issue(32'h4, 32'h5, 32'h6, 2'b00, 3'd0, 32'h22222222, 8'h04);
    ret(2'd3, 32'hDEADBEEF, 8'hFF);
    @(negedge clk);
    chk("err_not_outstanding", err_o, 1);
    chk("rob_unchanged_t3", rsp_valid_o, 0);
    cyc();
    ret(2'd0, 32'h11111111, 8'h00);
    ret(2'd1, 32'h22222222, 8'h04);
    repeat (3) cyc();
    @(negedge clk);
    chk("err_sticky", err_o, 1);
    cyc();

    // Duplicate result for an already-done tag.
    do_reset();
    issue(32'h7, 32'h8, 32'h9, 2'b11, 3'd2, 32'h33333333, 8'h08);
    ret(2'd0, 32'h33333333, 8'h08);
    @(negedge clk);
    chk("err_clean_write", err_o, 0);
    cyc();
    ret(2'd0, 32'hBADBAD00, 8'hEE);
    @(negedge clk);
    chk("err_duplicate", err_o, 1);
    chk("rob_kept_res", rsp_res_o, 32'h33333333);
    chk("rob_kept_status", rsp_status_o, 8'h08);
    cyc();
    rsp_ready_i = 1'b1;
    repeat (2) cyc();

    // Reset with three ops outstanding; stale results are errors.
    do_reset();
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++)
      issue(32'hA0 + i, 32'hB0, 32'hC0, 2'b00, 3'd0, rv[i], sv[i]);
    do_reset();
    rsp_ready_i = 1'b1;
    issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00, 3'd0, 32'h40E00000, 8'h00);
    ret(2'd2, 32'hCAFEF00D, 8'h00);
    @(negedge clk);
    chk("err_stale_tag", err_o, 1);
    cyc();
    ret(2'd0, 32'h40E00000, 8'h00);
    repeat (3) cyc();

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
